// File: rtl/card7seg_bank.sv
// Bank of independently loaded card registers, each decoded to a 7-segment digit,
// with an optional fixed-length on/off flash after a visible card is dealt.
module card7seg_bank #(
    parameter int NUM_CARDS    = 6,
    parameter int FLASH_HALF   = 4,
    parameter int FLASH_PHASES = 6,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                     slow_clock,
    input  logic                     resetb,
    input  logic [NUM_CARDS-1:0]     load,
    input  logic [4*NUM_CARDS-1:0]   card_in,
    input  logic                     flash_en,
    input  logic                     clear,
    output logic [7*NUM_CARDS-1:0]   hex_out,
    output logic [NUM_CARDS-1:0]     busy
);

    localparam int TW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int PW = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(FLASH_HALF - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_PHASES - 1);
    localparam logic          INVERT     = (ACTIVE_LOW == 0);

    logic [3:0]           card_q  [NUM_CARDS];
    logic [3:0]           card_d  [NUM_CARDS];
    logic [TW-1:0]        tick_q  [NUM_CARDS];
    logic [TW-1:0]        tick_d  [NUM_CARDS];
    logic [PW-1:0]        phase_q [NUM_CARDS];
    logic [PW-1:0]        phase_d [NUM_CARDS];
    logic [NUM_CARDS-1:0] flash_q;
    logic [NUM_CARDS-1:0] flash_d;

    function automatic logic [6:0] seg_al(input logic [3:0] v);
        case (v)
            4'd1:    seg_al = 7'b0001000;
            4'd2:    seg_al = 7'b0100100;
            4'd3:    seg_al = 7'b0110000;
            4'd4:    seg_al = 7'b0011001;
            4'd5:    seg_al = 7'b0010010;
            4'd6:    seg_al = 7'b0000010;
            4'd7:    seg_al = 7'b1111000;
            4'd8:    seg_al = 7'b0000000;
            4'd9:    seg_al = 7'b0010000;
            4'd10:   seg_al = 7'b1000000;
            4'd11:   seg_al = 7'b1100001;
            4'd12:   seg_al = 7'b0011000;
            4'd13:   seg_al = 7'b0001001;
            default: seg_al = 7'b1111111;
        endcase
    endfunction

    // Priority, lowest to highest: flash progress, load, clear.
    always_comb begin
        card_d  = card_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        flash_d = flash_q;
        for (int unsigned i = 0; i < NUM_CARDS; i++) begin
            if (flash_q[i]) begin
                if (tick_q[i] == TICK_LAST) begin
                    tick_d[i] = '0;
                    if (phase_q[i] == PHASE_LAST) begin
                        flash_d[i] = 1'b0;
                        phase_d[i] = '0;
                    end else begin
                        phase_d[i] = phase_q[i] + 1'b1;
                    end
                end else begin
                    tick_d[i] = tick_q[i] + 1'b1;
                end
            end
            if (load[i]) begin
                card_d[i]  = card_in[4*i +: 4];
                tick_d[i]  = '0;
                phase_d[i] = '0;
                flash_d[i] = flash_en && (card_in[4*i +: 4] inside {[4'd1:4'd13]});
            end
            if (clear) begin
                card_d[i]  = '0;
                tick_d[i]  = '0;
                phase_d[i] = '0;
                flash_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int unsigned i = 0; i < NUM_CARDS; i++) begin
                card_q[i]  <= '0;
                tick_q[i]  <= '0;
                phase_q[i] <= '0;
            end
            flash_q <= '0;
        end else begin
            card_q  <= card_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            flash_q <= flash_d;
        end
    end

    // Odd phases of a flash show blank.
    always_comb begin
        hex_out = '0;
        for (int unsigned i = 0; i < NUM_CARDS; i++) begin
            logic [6:0] pat;
            pat = (flash_q[i] && phase_q[i][0]) ? 7'b1111111 : seg_al(card_q[i]);
            hex_out[7*i +: 7] = INVERT ? ~pat : pat;
        end
    end

    assign busy = flash_q;

endmodule

// File: doc/card7seg_bank.md
Name: card7seg_bank

Overview:
- Multi-channel card display driver for the baccarat datapath.
- Holds NUM_CARDS card registers, each loaded by its own strobe.
- Decodes every register to a 7-segment pattern (A, 2-10, J, q, K, blank).
- Optionally flashes a newly dealt card for a fixed number of on/off phases. Sits between the dealer/player card registers and the HEX outputs, replacing the per-digit combinational decoders.

Parameters:
- NUM_CARDS, 6: number of independent card channels/digits (1..8).
- FLASH_HALF, 4: slow_clock cycles per flash phase (>=1).
- FLASH_PHASES, 6: number of flash phases after a load; even, >=2.
- ACTIVE_LOW, 1: 1 = segment on is 0 (DE-series HEX); 0 = outputs inverted.

Ports:
- slow_clock  in  1  rising-edge clock.
- resetb  in  1  asynchronous, active-low reset.
- load  in  NUM_CARDS  per-channel load strobe; bit i loads channel i.
- card_in  in  4*NUM_CARDS  card values; channel i = card_in[4i+3:4i].
- flash_en  in  1  when 1, a load of a visible card starts a flash sequence.
- clear  in  1  synchronous clear of all channels.
- hex_out  out  7*NUM_CARDS  segments; channel i = hex_out[7i+6:7i], bit order {g,f,e,d,c,b,a}.
- busy  out  NUM_CARDS  channel i is currently flashing.

Behaviour:
- State per channel:
  - card_reg (4b)
  - tick_cnt (0..FLASH_HALF-1)
  - phase_cnt (0..FLASH_PHASES-1)
  - flashing flag
- Reset (resetb=0, asynchronous): all card_reg=0, all counters=0, flashing=0. Outputs: busy=0, every digit blank (7'b1111111 when ACTIVE_LOW=1, 7'b0000000 when ACTIVE_LOW=0).
- Decode (active-low values; ACTIVE_LOW=0 is bitwise inverse):
  - 0 blank 1111111
  - 1 A 0001000
  - 2 0100100
  - 3 0110000
  - 4 0011001
  - 5 0010010
  - 6 0000010
  - 7 1111000
  - 8 0000000
  - 9 0010000
  - 10 "0" 1000000
  - 11 J 1100001
  - 12 q 0011000
  - 13 K 0001001
  - 14, 15 blank
- Load: load[i]=1 at an edge stores card_in slice into card_reg[i]. hex_out reflects the new value from the same edge; decode is combinational from registers, so latency is 1 cycle from the strobe.
- Flash start: load[i]=1, flash_en=1 and card_in slice in 1..13 sets flashing, phase_cnt=0, tick_cnt=0. Otherwise any in-progress flash on channel i is cancelled.
- Flash progress, each cycle while flashing:
  - If tick_cnt=FLASH_HALF-1: tick_cnt<=0 and phase_cnt advances.
  - Otherwise tick_cnt increments.
  - When phase_cnt=FLASH_PHASES-1 and tick wraps, flashing clears.
- Display during flash: phase_cnt even shows the card; phase_cnt odd shows blank. Flash duration is FLASH_PHASES*FLASH_HALF cycles. busy[i]=flashing[i].
- Reload while flashing restarts the sequence from phase 0 with the new value.
- flash_en is sampled only at load. Deasserting it mid-flash does not stop the flash.
- Priority when clear=1: clear wins over every load in the same cycle. All card_reg=0, all flashes cancelled, busy=0 next cycle.
- Channels are fully independent. Simultaneous loads on several channels are all honoured.
- Reset asserted mid-flash: immediate return to reset state, with no waiting for a clock edge.

Test Plan:
- Reset, then idle 5 cycles -> hex_out all 1111111, busy=0.
- flash_en=0, load[0]=1 with card 1; next cycle load[1]=1 with card 13 -> ch0=0001000 after 1st edge; ch1=0001001 after 2nd edge; busy stays 0.
- Defaults, flash_en=1, load ch2 with 12 -> for 24 cycles busy[2]=1:
  - cycles 1-4 show 0011000
  - cycles 5-8 blank
  - pattern alternates
  - cycle 25: busy[2]=0, steady 0011000.
- Load ch3 with 7 while flashing, reload with 9 at cycle 6 -> phase restarts, digit immediately 0010000, busy held 24 more cycles. Load of 14 with flash_en=1 -> blank, busy=0.
- clear=1 and load[0]=1 (card 5) in the same cycle -> all digits blank, busy=0, ch0 not loaded.
- ACTIVE_LOW=0, load card 8 -> 1111111. Assert resetb low mid-flash between edges -> outputs 0000000 and busy=0 before the next clock edge.
